// File: rtl/piezo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : piezo_arbiter
//  Purpose  : Three-channel arbiter for a single piezo tone generator. ch0 is
//             the alert channel: it has absolute priority, preempts ch1/ch2
//             immediately and is never preempted itself. ch1 and ch2 share the
//             generator round-robin, and an owner is rotated out only after it
//             has played for MIN_HOLD cycles. All outputs are registered.
//  Ports    : clk            - sole clock, rising edge
//             rst            - asynchronous active-high reset
//             req[2:0]       - per-channel request (ch0 = alert)
//             tones[71:0]    - channel i switch period at [24*i+23:24*i]
//             grant[2:0]     - one-hot grant to the owner, zero when idle
//             tone[23:0]     - switch period of the owner, zero when idle
//             output_enable  - tone generator enable
//             active_ch[1:0] - encoded owner, 3 when no owner
//  Options  : PIEZO_ARBITER_GAP_EN - when defined, every owner switch passes
//             through GAP_CYCLES cycles of silence before the next owner is
//             chosen; otherwise the switch is PLAY->PLAY on the next edge.
//  Revision : 1.0 - initial release
// ============================================================================
module piezo_arbiter #(
    parameter int MIN_HOLD   = 33000,
    parameter int GAP_CYCLES = 3300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [71:0] tones,
    output logic [2:0]  grant,
    output logic [23:0] tone,
    output logic        output_enable,
    output logic [1:0]  active_ch
);

    localparam int c_hold_w = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam int c_gap_w  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // The cycle being completed counts toward the hold, so an owner is rotated
    // out on the edge that ends its MIN_HOLD-th cycle of play.
    localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(MIN_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'((MIN_HOLD > 0) ? MIN_HOLD - 1 : 0);
    localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [1:0]          c_no_owner  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                r_state;
    logic [1:0]            r_owner;
    logic [1:0]            r_rr_last;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic [c_gap_w-1:0]    r_gap_cnt;
    logic [2:0]            r_grant;
    logic [23:0]           r_tone;
    logic                  r_oe;
    logic [1:0]            r_active_ch;

    state_t                w_state_nxt;
    logic [1:0]            w_owner_nxt;
    logic [1:0]            w_rr_last_nxt;
    logic [c_hold_w-1:0]   w_hold_nxt;
    logic [c_gap_w-1:0]    w_gap_nxt;
    logic [1:0]            w_pick;
    logic                  w_owner_req;
    logic                  w_peer_req;
    logic                  w_hold_done;
    logic                  w_switch;
    logic                  w_go_play;
    logic [1:0]            w_go_owner;
    logic [2:0]            w_grant_nxt;
    logic [23:0]           w_tone_nxt;
    logic                  w_oe_nxt;
    logic [1:0]            w_active_nxt;

    // Winner selection: ch0 first, then the ch1/ch2 requester that follows
    // the last round-robin owner. Returns 3 when nobody requests.
    function automatic logic [1:0] pick_winner(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] win;
        win = c_no_owner;
        if (r[0]) begin
            win = 2'd0;
        end else if (last == 2'd1) begin
            if (r[2])      win = 2'd2;
            else if (r[1]) win = 2'd1;
        end else begin
            if (r[1])      win = 2'd1;
            else if (r[2]) win = 2'd2;
        end
        return win;
    endfunction

    function automatic logic [23:0] tone_of(input logic [1:0] ch, input logic [71:0] t);
        logic [23:0] v;
        case (ch)
            2'd0:    v = t[23:0];
            2'd1:    v = t[47:24];
            2'd2:    v = t[71:48];
            default: v = 24'd0;
        endcase
        return v;
    endfunction

    assign w_pick      = pick_winner(req, r_rr_last);
    assign w_hold_done = (r_hold_cnt >= c_hold_last);

    always_comb begin
        w_owner_req = 1'b0;
        w_peer_req  = 1'b0;
        case (r_owner)
            2'd0: w_owner_req = req[0];
            2'd1: begin
                w_owner_req = req[1];
                w_peer_req  = req[2];
            end
            2'd2: begin
                w_owner_req = req[2];
                w_peer_req  = req[1];
            end
            default: w_owner_req = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_rr_last_nxt = r_rr_last;
        w_hold_nxt    = r_hold_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_switch      = 1'b0;
        w_go_play     = 1'b0;
        w_go_owner    = r_owner;

        case (r_state)
            ST_IDLE: begin
                if (w_pick != c_no_owner) begin
                    w_go_play  = 1'b1;
                    w_go_owner = w_pick;
                end
            end

            ST_PLAY: begin
                if (!w_owner_req) begin
                    // Release: hand over if anyone else waits, else go quiet.
                    if (req != 3'b000) begin
                        w_switch = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_owner_nxt = c_no_owner;
                    end
                end else if (r_owner != 2'd0 && req[0]) begin
                    w_switch = 1'b1;
                end else if (r_owner != 2'd0 && w_peer_req && w_hold_done) begin
                    w_switch = 1'b1;
                end else if (r_hold_cnt != c_hold_max) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    if (w_pick != c_no_owner) begin
                        w_go_play  = 1'b1;
                        w_go_owner = w_pick;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_owner_nxt = c_no_owner;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = c_no_owner;
            end
        endcase

        // While a ch1/ch2 owner holds, r_rr_last equals that owner, so the
        // winner picked here is always the party that caused the switch.
        if (w_switch) begin
`ifdef PIEZO_ARBITER_GAP_EN
            w_state_nxt = ST_GAP;
            w_owner_nxt = c_no_owner;
            w_gap_nxt   = '0;
`else
            w_go_play  = 1'b1;
            w_go_owner = w_pick;
`endif
        end

        if (w_go_play) begin
            w_state_nxt = ST_PLAY;
            w_owner_nxt = w_go_owner;
            w_hold_nxt  = '0;
            if (w_go_owner != 2'd0) begin
                w_rr_last_nxt = w_go_owner;
            end
        end
    end

    // Output values for the next cycle, derived from the next state so the
    // registered outputs line up with the state register.
    always_comb begin
        w_grant_nxt  = 3'b000;
        w_tone_nxt   = 24'd0;
        w_oe_nxt     = 1'b0;
        w_active_nxt = c_no_owner;
        if (w_state_nxt == ST_PLAY) begin
            case (w_owner_nxt)
                2'd0:    w_grant_nxt = 3'b001;
                2'd1:    w_grant_nxt = 3'b010;
                2'd2:    w_grant_nxt = 3'b100;
                default: w_grant_nxt = 3'b000;
            endcase
            w_tone_nxt   = tone_of(w_owner_nxt, tones);
            w_oe_nxt     = 1'b1;
            w_active_nxt = w_owner_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= c_no_owner;
            r_rr_last   <= 2'd2;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_grant     <= 3'b000;
            r_tone      <= 24'd0;
            r_oe        <= 1'b0;
            r_active_ch <= c_no_owner;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_last   <= w_rr_last_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_grant     <= w_grant_nxt;
            r_tone      <= w_tone_nxt;
            r_oe        <= w_oe_nxt;
            r_active_ch <= w_active_nxt;
        end
    end

    assign grant         = r_grant;
    assign tone          = r_tone;
    assign output_enable = r_oe;
    assign active_ch     = r_active_ch;

endmodule
`default_nettype wire

// File: tb/tb_piezo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piezo_arbiter
//  Purpose  : Directed self-checking bench for piezo_arbiter with MIN_HOLD=8
//             and GAP_CYCLES=4, plus a random request stress for grant
//             consistency. Expectations follow the PIEZO_ARBITER_GAP_EN setting.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piezo_arbiter;

    localparam int c_min_hold = 8;
    localparam int c_gap      = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] t0, t1, t2;
    logic [71:0] tones;
    logic [2:0]  grant;
    logic [23:0] tone;
    logic        output_enable;
    logic [1:0]  active_ch;

    int n_checks = 0;
    int n_errors = 0;

    assign tones = {t2, t1, t0};

    piezo_arbiter #(
        .MIN_HOLD   (c_min_hold),
        .GAP_CYCLES (c_gap)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .tones         (tones),
        .grant         (grant),
        .tone          (tone),
        .output_enable (output_enable),
        .active_ch     (active_ch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_grant"}, 32'(grant), 32'h0);
        check_val({tag, "_tone"}, 32'(tone), 32'h0);
        check_val({tag, "_oe"}, 32'(output_enable), 32'h0);
        check_val({tag, "_active"}, 32'(active_ch), 32'h3);
    endtask

    initial begin
        logic [1:0] exp_act;
        logic       ok;

        rst = 1'b1;
        req = 3'b000;
        t0  = 24'h00AAAA;
        t1  = 24'h001111;
        t2  = 24'h002222;
        #2;
        check_idle("reset");
        tick();
        tick();
        rst = 1'b0;

        // Simultaneous ch1/ch2 after reset: ch1 first, rotate after 8 cycles
        req = 3'b110;
        tick();
        check_val("first_grant", 32'(grant), 32'h2);
        check_val("first_tone", 32'(tone), 32'h001111);
        check_val("first_active", 32'(active_ch), 32'h1);
        check_val("first_oe", 32'(output_enable), 32'h1);
        repeat (c_min_hold - 1) tick();
        check_val("hold_last_cycle", 32'(grant), 32'h2);
        tick();
`ifdef PIEZO_ARBITER_GAP_EN
        check_idle("rot_gap_start");
        repeat (c_gap - 1) tick();
        check_val("rot_gap_end_oe", 32'(output_enable), 32'h0);
        tick();
`endif
        check_val("rot_grant", 32'(grant), 32'h4);
        check_val("rot_tone", 32'(tone), 32'h002222);
        check_val("rot_active", 32'(active_ch), 32'h2);

        // ch2 owning alone, then drops: straight back to idle
        req = 3'b100;
        tick();
        check_val("ch2_keep", 32'(grant), 32'h4);
        req = 3'b000;
        tick();
        check_idle("ch2_release");

        // ch1 owning for two cycles, alert arrives with ch2 also waiting
        req = 3'b010;
        tick();
        check_val("ch1_grant", 32'(grant), 32'h2);
        tick();
        tick();
        req = 3'b111;
        tick();
`ifdef PIEZO_ARBITER_GAP_EN
        check_val("preempt_gap_oe", 32'(output_enable), 32'h0);
        repeat (c_gap) tick();
`endif
        check_val("preempt_grant", 32'(grant), 32'h1);
        check_val("preempt_tone", 32'(tone), 32'h00AAAA);
        check_val("preempt_active", 32'(active_ch), 32'h0);
        for (int i = 0; i < 50; i++) begin
            tick();
            check_val("ch0_kept", 32'(grant), 32'h1);
        end
        req = 3'b000;
        tick();
        check_idle("ch0_release");

        // Live tone tracking with one-cycle latency, zero passes through
        req = 3'b010;
        tick();
        check_val("track_grant", 32'(grant), 32'h2);
        t1 = 24'h003333;
        #1;
        check_val("tone_still_old", 32'(tone), 32'h001111);
        tick();
        check_val("tone_new", 32'(tone), 32'h003333);
        t1 = 24'h000000;
        tick();
        check_val("tone_zero", 32'(tone), 32'h0);
        check_val("tone_zero_oe", 32'(output_enable), 32'h1);
        t1 = 24'h001111;
        tick();

        // Asynchronous reset mid-PLAY, then rr_last back to favouring ch1
        rst = 1'b1;
        #1;
        check_idle("rst_play");
        tick();
        rst = 1'b0;
        req = 3'b110;
        tick();
        check_val("post_rst_grant", 32'(grant), 32'h2);
        check_val("post_rst_tone", 32'(tone), 32'h001111);
`ifdef PIEZO_ARBITER_GAP_EN
        req = 3'b011;
        tick();
        check_val("gap_entered", 32'(output_enable), 32'h0);
        tick();
        rst = 1'b1;
        #1;
        check_idle("rst_gap");
        tick();
        rst = 1'b0;
        req = 3'b110;
        tick();
        check_val("post_gap_rst_grant", 32'(grant), 32'h2);
`endif
        req = 3'b000;
        tick();
        check_idle("pre_stress");

        // Random request stress: grant one-hot or zero, outputs consistent
        for (int i = 0; i < 10000; i++) begin
            req = 3'($urandom_range(0, 7));
            tick();
            ok = ((grant & (grant - 3'b001)) == 3'b000);
            check_val("onehot", 32'(ok), 32'h1);
            case (grant)
                3'b001:  exp_act = 2'd0;
                3'b010:  exp_act = 2'd1;
                3'b100:  exp_act = 2'd2;
                default: exp_act = 2'd3;
            endcase
            check_val("active_vs_grant", 32'(active_ch), 32'(exp_act));
            check_val("oe_vs_grant", 32'(output_enable), 32'(grant != 3'b000));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piezo_arbiter.md
PIEZO_ARBITER -- requirements
Module: piezo_arbiter

Interface
REQ-001 Parameter MIN_HOLD, default 33000, minimum grant cycles before a round-robin owner is rotated out (≈1 ms at 33 MHz).
REQ-002 Parameter GAP_CYCLES, default 3300, length in cycles of the silence gap inserted on an owner switch.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  3  per-channel request; ch0 is the alert channel, ch1/ch2 are round-robin peers.
REQ-006 tones  input  72  channel i switch period at bits [24*i+23:24*i].
REQ-007 grant  output  3  one-hot grant to the current owner; all zero when no owner.
REQ-008 tone  output  24  switch period driven to the tone generator.
REQ-009 output_enable  output  1  tone generator enable.
REQ-010 active_ch  output  2  encoded owner: 0, 1 or 2; 3 means no owner.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, PLAY and GAP; all outputs SHALL be registered.
REQ-012 In IDLE and GAP the block SHALL drive grant=0, tone=0, output_enable=0 and active_ch=3.
REQ-013 Winner selection SHALL give ch0 absolute priority; otherwise it SHALL grant the ch1/ch2 requester after rr_last in rotation; rr_last SHALL update only when ch1 or ch2 is granted.
REQ-014 IDLE with any req bit high SHALL enter PLAY with the selected owner on the next edge; this gives one-cycle request-to-grant latency.
REQ-015 In PLAY the block SHALL drive grant[owner]=1, output_enable=1 and active_ch=owner, and SHALL register tone from the owner's live tones slice every cycle (one-cycle latency).
REQ-016 On entry to PLAY hold_cnt SHALL be cleared; it SHALL increment each PLAY cycle and saturate at MIN_HOLD.
REQ-017 When the owner deasserts req, the owner SHALL be released at the next edge regardless of hold_cnt.
REQ-018 When req[0] rises while the owner is ch1 or ch2, the block SHALL preempt immediately regardless of hold_cnt.
REQ-019 When the owner is ch1 or ch2 and the peer requests, the block SHALL switch once hold_cnt reaches MIN_HOLD.
REQ-020 ch0 SHALL never be preempted; it SHALL hold the grant while req[0] stays high.
REQ-021 On release with no other request, the block SHALL return to IDLE; on release or switch with a pending request, it SHALL perform an owner switch (REQ-028/029).
REQ-022 On simultaneous requests, priority SHALL be ch0 first, then round-robin order; after reset, ch1 SHALL win over ch2.
REQ-023 A tone value of 0 from the owner SHALL pass through unmodified.
REQ-024 At most one grant bit SHALL be high in any cycle.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE with grant=0, tone=0, output_enable=0 and active_ch=3, including when asserted mid-PLAY or mid-GAP.
REQ-026 Reset SHALL clear hold_cnt and the gap counter and SHALL set rr_last=2.
REQ-027 The first grant SHALL be possible on the first edge after rst deasserts.

Configuration
REQ-028 With PIEZO_ARBITER_GAP_EN defined, an owner switch SHALL enter GAP for exactly GAP_CYCLES cycles, then re-run winner selection: it SHALL enter PLAY if any req is high, otherwise IDLE; a req[0] rising during GAP SHALL win at gap end.
REQ-029 Without PIEZO_ARBITER_GAP_EN, an owner switch SHALL go directly from PLAY to PLAY with the new owner on the next edge; GAP SHALL be unreachable and GAP_CYCLES ignored.

Verification (bench uses MIN_HOLD=8, GAP_CYCLES=4, tones ch0=24'h00AAAA, ch1=24'h001111, ch2=24'h002222)
REQ-030 req=3'b110 after reset -> grant=3'b010 and tone=24'h001111 one cycle later; grant=3'b100 after 8 PLAY cycles, plus a 4-cycle output_enable=0 gap when GAP_EN is defined.
REQ-031 ch1 owning with hold_cnt=2 and req[0] raised -> grant moves to ch0 without waiting for MIN_HOLD; ch0 is kept for 50 cycles despite req[2] high.
REQ-032 ch2 owning, req[2] dropped with no other request -> next edge IDLE, active_ch=3, output_enable=0.
REQ-033 ch1 owning while tones ch1 changes to 24'h003333 -> tone=24'h003333 exactly one cycle later.
REQ-034 rst pulsed mid-GAP and mid-PLAY -> outputs zero with no clock edge required; req=3'b110 afterwards -> ch1 granted first.
REQ-035 Random req stress over 10000 cycles -> grant is always one-hot or zero and active_ch is always consistent with grant.
